// File: rtl/mmss_countdown.sv
// rtl/mmss_countdown.sv - minute:second countdown timer with prescaler, hold, clear and auto-reload
module mmss_countdown #(
  parameter int MIN_W       = 3,
  parameter int TICK_DIV    = 1,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             SYSCLK,
  input  logic             RST_B,
  input  logic [MIN_W-1:0] TIME_MIN,
  input  logic [5:0]       TIME_SEC,
  input  logic             START,
  input  logic             PAUSE,
  input  logic             CLEAR,
  output logic [MIN_W-1:0] MINUTE,
  output logic [5:0]       SECOND,
  output logic             TIME_UP,
  output logic             RUNNING
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [MIN_W-1:0] min_q, min_d, rld_min_q, rld_min_d;
  logic [5:0]       sec_q, sec_d, rld_sec_q, rld_sec_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             up_q, up_d;

  logic [5:0] ld_sec;
  logic       ld_zero, rld_zero, tick, at_one;

  assign ld_sec   = (TIME_SEC > 6'd59) ? 6'd59 : TIME_SEC;
  assign ld_zero  = (TIME_MIN == '0) && (ld_sec == 6'd0);
  assign rld_zero = (rld_min_q == '0) && (rld_sec_q == 6'd0);
  assign tick     = (pre_q == PRE_MAX);
  // 0:01 is the last value before expiry; detecting it stops the count before the minute field can wrap
  assign at_one   = (min_q == '0) && (sec_q == 6'd1);

  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    sec_d     = sec_q;
    pre_d     = pre_q;
    up_d      = up_q;
    rld_min_d = rld_min_q;
    rld_sec_d = rld_sec_q;
    if (CLEAR) begin
      state_d = S_IDLE;
      min_d   = '0;
      sec_d   = 6'd0;
      pre_d   = '0;
      up_d    = 1'b0;
    end else if (START) begin
      min_d     = TIME_MIN;
      sec_d     = ld_sec;
      rld_min_d = TIME_MIN;
      rld_sec_d = ld_sec;
      pre_d     = '0;
      up_d      = ld_zero;
      state_d   = ld_zero ? S_DONE : S_RUN;
    end else begin
      case (state_q)
        // Leaving HOLD counts on the same edge so the pause costs exactly its own cycles
        S_RUN, S_HOLD: begin
          if (PAUSE) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_RUN;
            if (tick) begin
              pre_d = '0;
              if (at_one) begin
                sec_d   = 6'd0;
                up_d    = 1'b1;
                state_d = S_DONE;
              end else if (sec_q != 6'd0) begin
                sec_d = sec_q - 6'd1;
              end else begin
                sec_d = 6'd59;
                min_d = min_q - 1'b1;
              end
            end else begin
              pre_d = pre_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (AUTO_RELOAD && !rld_zero) begin
            min_d   = rld_min_q;
            sec_d   = rld_sec_q;
            pre_d   = '0;
            up_d    = 1'b0;
            state_d = S_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge SYSCLK or negedge RST_B) begin
    if (!RST_B) begin
      state_q   <= S_IDLE;
      min_q     <= '0;
      sec_q     <= 6'd0;
      pre_q     <= '0;
      up_q      <= 1'b0;
      rld_min_q <= '0;
      rld_sec_q <= 6'd0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      pre_q     <= pre_d;
      up_q      <= up_d;
      rld_min_q <= rld_min_d;
      rld_sec_q <= rld_sec_d;
    end
  end

  assign MINUTE  = min_q;
  assign SECOND  = sec_q;
  assign TIME_UP = up_q;
  assign RUNNING = (state_q == S_RUN);

endmodule

// File: tb/tb_mmss_countdown.sv
// tb/tb_mmss_countdown.sv - bench for mmss_countdown across three parameter sets
module tb_mmss_countdown;

  logic       clk = 1'b0, rst_b = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
  logic [2:0] tmin = 3'd0;
  logic [5:0] tsec = 6'd0;
  logic [2:0] mn [3];
  logic [5:0] sc [3];
  logic       tu [3];
  logic       rn [3];

  int errors = 0, checks = 0;
  int div_a [3] = '{1, 4, 1};
  int ar_a  [3] = '{0, 0, 1};
  int rem [3], ph [3], md [3], up [3], rl [3];
  localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_DONE = 3;

  always #5 clk = ~clk;

  mmss_countdown #(.MIN_W(3), .TICK_DIV(1), .AUTO_RELOAD(1'b0)) u_d0 (
    .SYSCLK(clk), .RST_B(rst_b), .TIME_MIN(tmin), .TIME_SEC(tsec), .START(start),
    .PAUSE(pause), .CLEAR(clear), .MINUTE(mn[0]), .SECOND(sc[0]), .TIME_UP(tu[0]), .RUNNING(rn[0]));
  mmss_countdown #(.MIN_W(3), .TICK_DIV(4), .AUTO_RELOAD(1'b0)) u_d1 (
    .SYSCLK(clk), .RST_B(rst_b), .TIME_MIN(tmin), .TIME_SEC(tsec), .START(start),
    .PAUSE(pause), .CLEAR(clear), .MINUTE(mn[1]), .SECOND(sc[1]), .TIME_UP(tu[1]), .RUNNING(rn[1]));
  mmss_countdown #(.MIN_W(3), .TICK_DIV(1), .AUTO_RELOAD(1'b1)) u_d2 (
    .SYSCLK(clk), .RST_B(rst_b), .TIME_MIN(tmin), .TIME_SEC(tsec), .START(start),
    .PAUSE(pause), .CLEAR(clear), .MINUTE(mn[2]), .SECOND(sc[2]), .TIME_UP(tu[2]), .RUNNING(rn[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      rem[i] = 0; ph[i] = 0; md[i] = M_IDLE; up[i] = 0; rl[i] = 0;
    end
  endtask

  // Remaining time is kept as a plain count of seconds
  task automatic model_step();
    int total;
    total = int'(tmin) * 60 + ((tsec > 6'd59) ? 59 : int'(tsec));
    for (int i = 0; i < 3; i++) begin
      if (clear) begin
        rem[i] = 0; ph[i] = 0; md[i] = M_IDLE; up[i] = 0;
      end else if (start) begin
        rl[i] = total; rem[i] = total; ph[i] = 0;
        up[i] = (total == 0) ? 1 : 0;
        md[i] = (total == 0) ? M_DONE : M_RUN;
      end else if (md[i] == M_RUN || md[i] == M_HOLD) begin
        if (pause) begin
          md[i] = M_HOLD;
        end else begin
          md[i] = M_RUN;
          ph[i] = ph[i] + 1;
          if (ph[i] == div_a[i]) begin
            ph[i] = 0;
            rem[i] = rem[i] - 1;
            if (rem[i] == 0) begin
              md[i] = M_DONE; up[i] = 1;
            end
          end
        end
      end else if (md[i] == M_DONE && ar_a[i] == 1 && rl[i] != 0) begin
        rem[i] = rl[i]; ph[i] = 0; md[i] = M_RUN; up[i] = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++)
      chk($sformatf("%s/d%0d", tag, i), {21'b0, mn[i], sc[i], tu[i], rn[i]},
          {21'b0, 3'(rem[i] / 60), 6'(rem[i] % 60), up[i][0], md[i] == M_RUN});
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst_b) model_reset();
    else model_step();
    #1;
    check_all("cyc");
  endtask

  initial begin
    model_reset();
    repeat (2) cyc();
    chk("reset_d0", {mn[0], sc[0], tu[0], rn[0]}, 32'd0);
    rst_b = 1'b1;
    repeat (2) cyc();

    tmin = 3'd3; tsec = 6'd48; start = 1'b1; cyc(); start = 1'b0;
    chk("load_3m48", {mn[0], sc[0], rn[0]}, {3'd3, 6'd48, 1'b1});
    cyc();
    chk("first_dec", {mn[0], sc[0]}, {3'd3, 6'd47});
    repeat (226) cyc();
    chk("before_end", {mn[0], sc[0], tu[0]}, {3'd0, 6'd1, 1'b0});
    cyc();
    chk("end_228", {mn[0], sc[0], tu[0], rn[0]}, {3'd0, 6'd0, 1'b1, 1'b0});
    repeat (500) cyc();
    chk("held_500", {mn[0], sc[0], tu[0], rn[0]}, {3'd0, 6'd0, 1'b1, 1'b0});

    clear = 1'b1; cyc(); clear = 1'b0;
    chk("clear_d1", {mn[1], sc[1], tu[1], rn[1]}, 32'd0);
    tmin = 3'd0; tsec = 6'd2; start = 1'b1; cyc(); start = 1'b0;
    chk("div4_load", {sc[1], tu[1], rn[1]}, {6'd2, 1'b0, 1'b1});
    repeat (3) cyc();
    chk("div4_pretick", sc[1], 6'd2);
    cyc();
    chk("div4_tick", sc[1], 6'd1);
    pause = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk($sformatf("pause_%0d", k), {sc[1], rn[1]}, {6'd1, 1'b0});
    end
    pause = 1'b0;
    repeat (3) cyc();
    chk("div4_not_yet", tu[1], 1'b0);
    cyc();
    chk("div4_up_18", {mn[1], sc[1], tu[1], rn[1]}, {3'd0, 6'd0, 1'b1, 1'b0});

    tmin = 3'd0; tsec = 6'd0; start = 1'b1; cyc(); start = 1'b0;
    chk("zero_load", {tu[0], rn[0]}, {1'b1, 1'b0});
    clear = 1'b1; cyc(); clear = 1'b0;
    chk("zero_clear", {tu[0], rn[0]}, {1'b0, 1'b0});

    tsec = 6'd3; start = 1'b1; cyc(); start = 1'b0;
    chk("ar_load", {mn[2], sc[2], tu[2]}, {3'd0, 6'd3, 1'b0});
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk($sformatf("ar_%0d", k), {sc[2], tu[2]}, {6'(3 - (k % 4)), (k % 4) == 3});
    end

    tmin = 3'd1; tsec = 6'd63; start = 1'b1; cyc(); start = 1'b0;
    chk("clamp_59", {mn[0], sc[0]}, {3'd1, 6'd59});
    repeat (118) cyc();
    chk("clamp_pre", {mn[0], sc[0], tu[0]}, {3'd0, 6'd1, 1'b0});
    cyc();
    chk("clamp_119", {mn[0], sc[0], tu[0]}, {3'd0, 6'd0, 1'b1});

    tmin = 3'd2; tsec = 6'd20; start = 1'b1; cyc(); start = 1'b0;
    repeat (3) cyc();
    chk("at_2m17", {mn[0], sc[0]}, {3'd2, 6'd17});
    #2 rst_b = 1'b0;
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("async_rst/d%0d", i), {mn[i], sc[i], tu[i], rn[i]}, 32'd0);
    model_reset();
    repeat (3) cyc();
    rst_b = 1'b1; tmin = 3'd5; tsec = 6'd10;
    repeat (5) cyc();
    chk("post_rst_idle", {mn[0], sc[0], rn[0]}, 32'd0);
    start = 1'b1; cyc(); start = 1'b0;
    chk("post_rst_load", {mn[0], sc[0], tu[0], rn[0]}, {3'd5, 6'd10, 1'b0, 1'b1});

    for (int k = 0; k < 400; k++) begin
      start = ($urandom_range(15) == 0);
      clear = ($urandom_range(31) == 0);
      if ($urandom_range(7) == 0) pause = ~pause;
      tmin = 3'($urandom_range(1));
      tsec = 6'($urandom_range(63));
      cyc();
    end
    start = 1'b0; clear = 1'b0; pause = 1'b0;
    repeat (4) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmss_countdown.md
# mmss_countdown

Parameterised minute:second countdown timer, the next generation of the team's fixed-width TIMER block. It adds a configurable minute width, a second-tick prescaler, pause/hold, synchronous clear and optional auto-reload. It sits beside the control FSM and drives the MM:SS display and the alarm logic.

## Interface
- MIN_W, 3: width of the minute field; maximum minute value is 2^MIN_W-1.
- TICK_DIV, 1: SYSCLK cycles per one-second decrement, with 1 ≤ TICK_DIV ≤ 2^24. A value of 1 decrements every cycle (simulation mode).
- AUTO_RELOAD, 0: 0 = stop at 0:00 and hold the alarm; 1 = reload the last loaded value and keep running.
- SYSCLK, in, 1: single clock, rising edge.
- RST_B, in, 1: reset, asynchronous, active-low.
- TIME_MIN, in, MIN_W: minutes load value, sampled on START.
- TIME_SEC, in, 6: seconds load value, sampled on START; values above 59 clamp to 59.
- START, in, 1: load TIME_MIN/TIME_SEC and run. Single-cycle strobe; a held level reloads every cycle.
- PAUSE, in, 1: level; while high in RUN, counting and prescaler freeze.
- CLEAR, in, 1: synchronous return to IDLE, counters zeroed.
- MINUTE, out, MIN_W: current minutes.
- SECOND, out, 6: current seconds, 0..59.
- TIME_UP, out, 1: alarm flag.
- RUNNING, out, 1: high in RUN only.

## Operation
- States: IDLE, RUN, HOLD, DONE. Reset enters IDLE.
- Input priority each cycle: CLEAR > START > PAUSE > tick.
- CLEAR, from any state: go to IDLE; MINUTE=0, SECOND=0, TIME_UP=0, prescaler=0.
- START, from any state:
  - Latch the clamped load value into MINUTE/SECOND and into the reload registers.
  - Zero the prescaler, drop TIME_UP.
  - Go to RUN, or straight to DONE if the load value is 0:00 (TIME_UP=1).
- RUN:
  - The prescaler counts 0..TICK_DIV-1. Its wrap is the tick.
  - On tick: if SECOND>0, SECOND-1; else SECOND=59 and MINUTE-1.
  - The tick that produces 0:00 goes to DONE with TIME_UP=1 on the same edge.
- RUN to HOLD when PAUSE=1. HOLD back to RUN when PAUSE=0. The prescaler value is kept across HOLD, so no partial second is lost or gained.
- PAUSE has no effect in IDLE or DONE.
- DONE with AUTO_RELOAD=0:
  - MINUTE/SECOND stay 0:00 and TIME_UP stays high until START or CLEAR.
  - The tick source is ignored.
- DONE with AUTO_RELOAD=1:
  - TIME_UP is a one-cycle pulse.
  - On the next edge, MINUTE/SECOND take the reload registers, the prescaler is zeroed, and the state returns to RUN.
  - A reload value of 0:00 stays in DONE with TIME_UP held.
- MINUTE never wraps below 0. The 0:00 detection stops the count first.

## Timing
- Reset values: MINUTE=0, SECOND=0, TIME_UP=0, RUNNING=0, prescaler=0, reload registers=0, state=IDLE.
- Load latency: START sampled at edge N; the loaded value is visible after edge N, with RUNNING=1.
- First decrement at edge N+TICK_DIV.
- Total run time for load value M:S is (60·M+S)·TICK_DIV cycles, pause cycles excluded.
- TIME_UP rises on the same edge that MINUTE:SECOND becomes 0:00.
- PAUSE sampled high at edge K freezes the count from edge K on; RUNNING=0 after edge K.
- RST_B low mid-count forces all reset values immediately, without waiting for a clock edge. Deassertion is taken synchronously by downstream logic.
- START coincident with a tick: the load wins and the tick is discarded.
- START in HOLD: loads and runs even if PAUSE is still high. RUNNING=1 for one cycle, then HOLD on the next edge.

## Test plan
- TICK_DIV=1, load 3:48, START one cycle: 3:47 one cycle after load; 0:00 with TIME_UP=1 exactly 228 cycles after load; values held for 500 further cycles.
- TICK_DIV=4, load 0:02:
  - Pulse PAUSE for 10 cycles after the first decrement.
  - TIME_UP rises at load+8+10 cycles; SECOND reads 1 throughout the pause.
- Load 0:00 with START: DONE and TIME_UP=1 one cycle later; CLEAR then gives TIME_UP=0, RUNNING=0.
- AUTO_RELOAD=1, TICK_DIV=1, load 0:03:
  - TIME_UP pulses one cycle every 4 cycles.
  - MINUTE:SECOND sequence is 3,2,1,0,3,2,1,0,…
- Load TIME_SEC=63, TIME_MIN=1: SECOND reads 59, then the count reaches 0:00 after 119 ticks.
- RST_B low for 3 cycles mid-count at 2:17:
  - Outputs go to 0 asynchronously.
  - After release, no counting until START, which reloads from the current inputs.
